// File: rtl/prog_loader_if.sv
// prog_loader_if: byte stream into the loader and instruction-memory write bus out of it
//   in_valid/in_byte/in_last : producer -> loader stream, accepted when in_valid & in_ready
//   in_ready                 : loader -> producer
//   wr_en/wr_addr/wr_data    : loader -> instruction memory write port
interface prog_loader_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              in_valid;
   logic [7:0]        in_byte;
   logic              in_last;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   modport slave (
      input  in_valid, in_byte, in_last,
      output in_ready, wr_en, wr_addr, wr_data
   );
   modport master (
      output in_valid, in_byte, in_last,
      input  in_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: packs a byte stream into 16-bit words (high byte first), writes them to instruction memory from address 0, then releases the processor with a one-cycle start pulse
//   clk, reset(active-low sync) : clock and reset
//   bus (slave)                 : byte stream in, memory write port out
//   load_req                    : begin a new load (honoured only in IDLE/DONE)
//   proc_hold, start            : processor hold and start pulse
//   busy, done, word_count      : status
//   err_odd, err_overflow       : sticky load errors, cleared by the next load_req
module prog_loader #(
   parameter int unsigned DEPTH  = 128,
   parameter int          ADDR_W = 16,
   parameter int          DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   prog_loader_if.slave      bus,
   input  logic              load_req,
   output logic              proc_hold,
   output logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] word_count,
   output logic              err_odd,
   output logic              err_overflow
);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] LOAD_HI = 3'd1;
   localparam logic [2:0] LOAD_LO = 3'd2;
   localparam logic [2:0] WRITE   = 3'd3;
   localparam logic [2:0] RELEASE = 3'd4;
   localparam logic [2:0] START   = 3'd5;
   localparam logic [2:0] DONE    = 3'd6;
   // one extra bit so DEPTH == 2**ADDR_W still compares correctly
   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [ADDR_W-1:0] word_count_q, word_count_d;
   logic              err_odd_q, err_odd_d;
   logic              err_ovf_q, err_ovf_d;
   logic              last_q, last_d;
   logic              accept;
   logic              in_range;

   assign bus.in_ready = (state_q == LOAD_HI) || (state_q == LOAD_LO);
   assign accept       = bus.in_valid && bus.in_ready;
   assign in_range     = {1'b0, wr_addr_q} < DEPTH_W;

   always_comb begin
      state_d      = state_q;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      word_count_d = word_count_q;
      err_odd_d    = err_odd_q;
      err_ovf_d    = err_ovf_q;
      last_d       = last_q;
      case (state_q)
         IDLE, DONE: begin
            if (load_req) begin
               state_d      = LOAD_HI;
               wr_addr_d    = '0;
               word_count_d = '0;
               err_odd_d    = 1'b0;
               err_ovf_d    = 1'b0;
            end
         end
         LOAD_HI: begin
            if (accept) begin
               // a last byte landing in the high half is padded with a zero low byte
               wr_data_d = {bus.in_byte, bus.in_last ? 8'h00 : wr_data_q[DATA_W-9:0]};
               err_odd_d = err_odd_q | bus.in_last;
               last_d    = bus.in_last;
               state_d   = bus.in_last ? WRITE : LOAD_LO;
            end
         end
         LOAD_LO: begin
            if (accept) begin
               wr_data_d = {wr_data_q[DATA_W-1:8], bus.in_byte};
               last_d    = bus.in_last;
               state_d   = WRITE;
            end
         end
         WRITE: begin
            word_count_d = word_count_q + 1'b1;
            wr_addr_d    = &wr_addr_q ? wr_addr_q : wr_addr_q + 1'b1;
            err_ovf_d    = err_ovf_q | ~in_range;
            state_d      = last_q ? RELEASE : LOAD_HI;
         end
         RELEASE: state_d = START;
         START:   state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         word_count_q <= '0;
         err_odd_q    <= 1'b0;
         err_ovf_q    <= 1'b0;
         last_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         word_count_q <= word_count_d;
         err_odd_q    <= err_odd_d;
         err_ovf_q    <= err_ovf_d;
         last_q       <= last_d;
      end
   end

   assign bus.wr_en   = (state_q == WRITE) && in_range;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   // the processor is held everywhere except the tail of a completed load
   assign proc_hold    = !((state_q == RELEASE) || (state_q == START) || (state_q == DONE));
   assign start        = state_q == START;
   assign busy         = !((state_q == IDLE) || (state_q == DONE));
   assign done         = state_q == DONE;
   assign word_count   = word_count_q;
   assign err_odd      = err_odd_q;
   assign err_overflow = err_ovf_q;
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction memory that the processor's control unit reads through pc_addr.
- Accepts a byte stream over a valid/ready handshake and packs bytes into 16-bit instruction words, high byte first.
- Writes the words into instruction memory at consecutive addresses starting at 0, holding the processor idle throughout.
- Afterwards releases the processor and issues a one-cycle start pulse, so a program image loads and runs without resynthesis.

Parameters:
DEPTH, 128, number of instruction words the instruction memory holds; writes at address >= DEPTH are suppressed.
ADDR_W, 16, width of wr_addr and word_count; matches pc_addr.
DATA_W, 16, instruction word width; fixed at 2 bytes.

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
load_req  input  1  one-cycle request to begin a new program load
in_valid  input  1  in_byte/in_last valid this cycle
in_byte  input  8  stream byte
in_last  input  1  marks the final byte of the program
in_ready  output  1  loader accepts a byte this cycle when in_valid & in_ready
wr_en  output  1  instruction memory write strobe
wr_addr  output  ADDR_W  instruction memory write address
wr_data  output  DATA_W  instruction word to write
proc_hold  output  1  active-high hold to processor reset logic
start  output  1  one-cycle start pulse to processor
busy  output  1  high in any state except IDLE and DONE
done  output  1  high in DONE
word_count  output  ADDR_W  words accepted in the current load, including suppressed ones
err_odd  output  1  sticky: in_last arrived on a high byte
err_overflow  output  1  sticky: more than DEPTH words received

Behaviour:
- Reset (reset==0 at an edge):
  - State goes to IDLE.
  - in_ready=0, wr_en=0, wr_addr=0, wr_data=0, start=0, busy=0, done=0, word_count=0, err_odd=0, err_overflow=0.
  - proc_hold=1: the processor stays held until a program is loaded.
  - Reset mid-load aborts immediately; memory contents already written are left as they are.
- States: IDLE, LOAD_HI, LOAD_LO, WRITE, RELEASE, START, DONE.
- IDLE or DONE, load_req=1:
  - Go to LOAD_HI.
  - Clear wr_addr, word_count, err_odd and err_overflow.
  - Set proc_hold=1 and done=0.
- load_req in any other state is ignored.
- LOAD_HI:
  - in_ready=1.
  - On accept: latch in_byte into wr_data[15:8].
  - If in_last=1: set wr_data[7:0]=8'h00, set err_odd, mark last, go to WRITE.
  - Otherwise go to LOAD_LO.
- LOAD_LO:
  - in_ready=1.
  - On accept: latch in_byte into wr_data[7:0], record in_last, go to WRITE.
- WRITE, exactly one cycle:
  - in_ready=0.
  - wr_en=1 only if wr_addr < DEPTH; otherwise wr_en=0 and err_overflow is set.
  - word_count increments.
  - The next state's first cycle sees wr_addr incremented; wr_addr saturates at 2^ADDR_W-1.
  - Next state is RELEASE if last was recorded, else LOAD_HI.
- Throughput: at most 1 word per 3 cycles. No byte is ever dropped; the producer stalls on in_ready=0.
- Bytes received after DEPTH words are still consumed, so the stream drains and terminates normally.
- RELEASE: proc_hold=0. Next state START.
- START: start=1 for this single cycle. Next state DONE.
- DONE: done=1, busy=0, proc_hold=0. word_count and the error flags stay stable until the next load_req.
- No in_last ever arrives: the loader stays in LOAD_HI/LOAD_LO indefinitely with proc_hold=1. There is no timeout.
- wr_data and wr_addr are registered outputs. wr_data holds its last value when wr_en=0.

Test Plan:
- Reset, then load_req, then bytes 12 34 56 78(last) with in_valid held high:
  - wr_en pulses with (addr 0, 16'h1234) and (addr 1, 16'h5678).
  - word_count=2.
  - proc_hold falls in RELEASE; start is high exactly one cycle later; done=1 with no error flags.
- Same stream with in_valid toggled every other cycle: identical writes and order; no byte is accepted while in_ready=0.
- Bytes AB CD EF(last):
  - Second write is (addr 1, 16'hEF00).
  - err_odd=1, word_count=2, start pulses.
- DEPTH=4 override, 6 words streamed:
  - Writes occur only at addr 0..3.
  - word_count=6, err_overflow=1, start still pulses.
- Assert reset=0 during the second word of a load:
  - Next cycle state is IDLE, proc_hold=1, in_ready=0, counters are 0, and start never pulses.
- load_req issued in LOAD_LO is ignored. A second load_req in DONE restarts at addr 0 and clears word_count and the error flags.
